// File: rtl/nn_host_responder_if.sv
// Host packet bus between the NeuralNetwork host side and nn_host_responder.
// The host drives the write/read addresses; the responder returns read data and busy.
interface nn_host_responder_if #(
  parameter int MM_DEPTH = 17,
  parameter int MM_SIZE  = 16
);
  logic                write_enable;
  logic [MM_DEPTH-1:0] write_addr;
  logic [MM_SIZE-1:0]  write_data;
  logic [MM_DEPTH-1:0] read_addr;
  logic [MM_SIZE-1:0]  read_data;
  logic                busy;

  modport master (
    output write_enable, write_addr, write_data, read_addr,
    input  read_data, busy
  );

  modport slave (
    input  write_enable, write_addr, write_data, read_addr,
    output read_data, busy
  );
endinterface

// File: rtl/nn_host_responder.sv
// Memory-mapped host responder: result/status reads, posted data-window writes
// into the core load port, and the core start sequencer.
module nn_host_responder #(
  parameter int MM_DEPTH   = 17,
  parameter int MM_SIZE    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_AW     = MM_DEPTH - 3
) (
  input  logic                 clk,
  input  logic                 reset,
  nn_host_responder_if.slave   host,
  output logic                 mem_we,
  output logic [WIN_AW-1:0]    mem_addr,
  output logic [MM_SIZE-1:0]   mem_wdata,
  input  logic                 mem_ready,
  output logic [WIN_AW-1:0]    res_addr,
  input  logic [MM_SIZE-1:0]   res_data,
  output logic                 start,
  input  logic                 core_busy,
  input  logic                 core_done
);
  localparam int RW = MM_DEPTH - WIN_AW;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = WIN_AW + MM_SIZE;
  localparam logic [RW-1:0] REGION_RESULT = '0;
  localparam logic [RW-1:0] REGION_REG    = RW'(1);

  typedef enum logic [1:0] {IDLE, PEND, RUN} state_t;

  state_t              state;
  logic                done, overflow, busy_q;
  logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_nxt;
  logic [MM_SIZE-1:0]  rd_reg, status_word;
  logic                rd_res_sel;

  logic [RW-1:0]       wr_region, rd_region;
  logic [WIN_AW-1:0]   wr_off, rd_off;
  logic                wr_ctrl, wr_data, rd_result, rd_status;
  logic                fifo_empty, fifo_full, pop, push_ok, start_req, fsm_active_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_region = host.write_addr[MM_DEPTH-1:WIN_AW];
  assign wr_off    = host.write_addr[WIN_AW-1:0];
  assign rd_region = host.read_addr[MM_DEPTH-1:WIN_AW];
  assign rd_off    = host.read_addr[WIN_AW-1:0];

  assign wr_ctrl   = host.write_enable && (wr_region == REGION_REG) && (wr_off == '0);
  assign wr_data   = host.write_enable && (wr_region == REGION_REG) && (wr_off > WIN_AW'(1));
  assign rd_result = (rd_region == REGION_RESULT);
  assign rd_status = (rd_region == REGION_REG) && (rd_off == WIN_AW'(1));
  assign start_req = wr_ctrl && host.write_data[0];

  // Posted-write FIFO; a full FIFO still accepts a push when the head leaves the same cycle.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && mem_ready;
  assign push_ok    = wr_data && (!fifo_full || pop);

  assign mem_we = !fifo_empty;
  assign {mem_addr, mem_wdata} = fifo_empty ? '0 : fifo_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + CW'(1);
    else if (!push_ok && pop) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {wr_off - WIN_AW'(2), host.write_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      if (wr_data && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Mirrors the FSM transitions so busy can show the post-edge state.
  always_comb begin
    case (state)
      IDLE:    fsm_active_nxt = start_req;
      PEND:    fsm_active_nxt = 1'b1;
      RUN:     fsm_active_nxt = !core_done;
      default: fsm_active_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      start  <= 1'b0;
      done   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: if (start_req) begin
          state <= PEND;
          done  <= 1'b0;
        end
        PEND: if (fifo_empty && !core_busy) begin
          start <= 1'b1;
          state <= RUN;
        end
        RUN:  if (core_done) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (core_done) done <= 1'b1;
      busy_q <= (count_nxt != '0) || fsm_active_nxt || core_busy;
    end
  end

  always_comb begin
    status_word      = '0;
    status_word[5:0] = {3'(count), overflow, done, busy_q};
  end

  // Result reads register only the region select; the core memory supplies the data one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_res_sel <= 1'b0;
      rd_reg     <= '0;
    end else begin
      rd_res_sel <= rd_result;
      rd_reg     <= rd_status ? status_word : '0;
    end
  end

  assign res_addr       = rd_off;
  assign host.read_data = rd_res_sel ? res_data : rd_reg;
  assign host.busy      = busy_q;
endmodule

// File: tb/tb_nn_host_responder.sv
// Directed vector bench for nn_host_responder: per-cycle input/expected-output table
// plus hand-written sequences for post-reset quiet and the start handshake.
module tb_nn_host_responder;
  localparam int MM_DEPTH = 17;
  localparam int MM_SIZE  = 16;
  localparam int WIN_AW   = 14;
  localparam int U  = 'h1FFFF;
  localparam int ST = 'h04001;

  logic                clk = 1'b0;
  logic                reset;
  logic                mem_we, mem_ready, start, core_busy, core_done;
  logic [WIN_AW-1:0]   mem_addr, res_addr;
  logic [MM_SIZE-1:0]  mem_wdata, res_data;

  nn_host_responder_if #(.MM_DEPTH(MM_DEPTH), .MM_SIZE(MM_SIZE)) hif ();

  nn_host_responder #(
    .MM_DEPTH(MM_DEPTH), .MM_SIZE(MM_SIZE), .FIFO_DEPTH(4), .WIN_AW(WIN_AW)
  ) dut (
    .clk(clk), .reset(reset), .host(hif),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .res_addr(res_addr), .res_data(res_data),
    .start(start), .core_busy(core_busy), .core_done(core_done)
  );

  always #5 clk = ~clk;

  // Result memory stub: synchronous, returns address + 0x100.
  always @(posedge clk) res_data <= 16'(res_addr) + 16'h0100;

  typedef struct {
    logic        rst, we;
    logic [16:0] wa;
    logic [15:0] wd;
    logic [16:0] ra;
    logic        rdy, cb, cd;
    logic [15:0] e_rd;
    logic        e_busy, e_mwe;
    logic [13:0] e_maddr;
    logic [15:0] e_mwd;
    logic        e_start;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  function automatic vec_t mk(int rst, int we, int wa, int wd, int ra, int rdy, int cb, int cd,
                              int erd, int ebusy, int emwe, int emaddr, int emwd, int estart);
    vec_t v;
    v.rst = 1'(rst); v.we = 1'(we); v.wa = 17'(wa); v.wd = 16'(wd); v.ra = 17'(ra);
    v.rdy = 1'(rdy); v.cb = 1'(cb); v.cd = 1'(cd);
    v.e_rd = 16'(erd); v.e_busy = 1'(ebusy); v.e_mwe = 1'(emwe);
    v.e_maddr = 14'(emaddr); v.e_mwd = 16'(emwd); v.e_start = 1'(estart);
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset             = v.rst;
    hif.write_enable  = v.we;
    hif.write_addr    = v.wa;
    hif.write_data    = v.wd;
    hif.read_addr     = v.ra;
    mem_ready         = v.rdy;
    core_busy         = v.cb;
    core_done         = v.cd;
  endtask

  task automatic run_row(input int i, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    chk("read_data", i, 32'(hif.read_data), 32'(v.e_rd));
    chk("busy",      i, 32'(hif.busy),      32'(v.e_busy));
    chk("mem_we",    i, 32'(mem_we),        32'(v.e_mwe));
    chk("mem_addr",  i, 32'(mem_addr),      32'(v.e_maddr));
    chk("mem_wdata", i, 32'(mem_wdata),     32'(v.e_mwd));
    chk("start",     i, 32'(start),         32'(v.e_start));
  endtask

  initial begin
    int lat;
    drive(mk(1, 0, 0, 0, U, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //          rst we wa        wd     ra   rdy cb cd | rd     bsy mwe maddr mwd   st
    tbl.push_back(mk(1, 0, 0,        0,     U,   0, 0, 0,   0,     0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  0, 0, 0,   0,     0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 1, 'h04002,  512,   U,   1, 0, 0,   0,     1, 1, 0,    512,  0));
    tbl.push_back(mk(0, 1, 'h04005,  2000,  U,   1, 0, 0,   0,     1, 1, 3,    2000, 0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  1, 0, 0,   'h09,  0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  1, 0, 0,   0,     0, 0, 0,    0,    0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 1, 'h04010 + k, 'hA0 + k, U, 0, 0, 0, 0, 1, 1, 'h0E, 'hA0, 0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  0, 0, 0,   'h25,  1, 1, 'h0E, 'hA0, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     1, 1, 'h0F, 'hA1, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     1, 1, 'h10, 'hA2, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     1, 1, 'h11, 'hA3, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  1, 0, 0,   'h04,  0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 1, 'h04020,  'h55,  U,   0, 0, 0,   0,     1, 1, 'h1E, 'h55, 0));
    tbl.push_back(mk(0, 1, 'h04021,  'h66,  U,   0, 0, 0,   0,     1, 1, 'h1E, 'h55, 0));
    tbl.push_back(mk(0, 1, 'h04000,  1,     U,   0, 0, 0,   0,     1, 1, 'h1E, 'h55, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   0, 0, 0,   0,     1, 1, 'h1E, 'h55, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     1, 1, 'h1F, 'h66, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     1, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 0,   0,     1, 0, 0,    0,    1));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 1, 0,   0,     1, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   1, 0, 1,   0,     0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  1, 0, 0,   'h06,  0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     'h0, 1, 0, 0,   'h100, 0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     'h1, 1, 0, 0,   'h101, 0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 0, 0,        0,     'h2, 1, 0, 0,   'h102, 0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 1, 'h08000,  'h77,  'h08000, 1, 0, 0, 0,   0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 1, 'h00005,  'h77,  U,   1, 0, 0,   0,     0, 0, 0,    0,    0));
    tbl.push_back(mk(0, 1, 'h04030,  'h31,  U,   0, 0, 0,   0,     1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(0, 1, 'h04031,  'h32,  U,   0, 0, 0,   0,     1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(0, 1, 'h04032,  'h33,  U,   0, 0, 0,   0,     1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(0, 1, 'h04000,  1,     U,   0, 0, 0,   0,     1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  0, 0, 0,   'h1D,  1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(0, 0, 0,        0,     U,   0, 0, 1,   0,     1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(0, 0, 0,        0,     ST,  0, 0, 0,   'h1F,  1, 1, 'h2E, 'h31, 0));
    tbl.push_back(mk(1, 0, 0,        0,     U,   1, 0, 0,   0,     0, 0, 0,    0,    0));

    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    // Pending start and queued entries were discarded by reset: nothing may emerge.
    for (int c = 0; c < 6; c++) begin
      drive(mk(0, 0, 0, 0, U, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      chk("start_after_reset", c, 32'(start), 32'd0);
      chk("mem_we_after_reset", c, 32'(mem_we), 32'd0);
    end
    run_row(100, mk(0, 0, 0, 0, ST, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Start with an empty FIFO: one cycle in PEND, then the pulse.
    run_row(101, mk(0, 1, 'h04000, 1, U, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, U, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) lat = c;
    end
    chk("start_latency", 102, 32'(lat), 32'd1);

    // CTRL write during RUN must not re-arm the sequencer.
    run_row(103, mk(0, 1, 'h04000, 1, U, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    run_row(104, mk(0, 0, 0, 0, U, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++)
      run_row(105 + c, mk(0, 0, 0, 0, U, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_row(108, mk(0, 0, 0, 0, ST, 1, 0, 0, 'h02, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nn_host_responder.md
Name: nn_host_responder

Overview:
- Memory-mapped slave end of the host packet interface. The host drives write_enable/write_addr/write_data and read_addr.
- Decodes addresses into a result window, control/status registers and a data window.
- Posts data-window writes through a small FIFO into the core load port, sequences the core start pulse, and serves reads with fixed one-cycle latency.
- Sits between the host bus and the neural network core, inside the NeuralNetwork top.

Parameters:
MM_DEPTH, 17, host address width
MM_SIZE, 16, host data width
FIFO_DEPTH, 4, posted-write FIFO entries (power of two)
WIN_AW, 14, core-side address width (MM_DEPTH-3)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
write_enable  in  1  host write strobe, one packet per cycle
write_addr  in  MM_DEPTH  host write address
write_data  in  MM_SIZE  host write data
read_addr  in  MM_DEPTH  host read address, sampled every cycle
read_data  out  MM_SIZE  read result, one cycle after read_addr
busy  out  1  responder or core not idle
mem_we  out  1  core load-port write strobe
mem_addr  out  WIN_AW  core load-port address
mem_wdata  out  MM_SIZE  core load-port data
mem_ready  in  1  core accepts mem_we this cycle
res_addr  out  WIN_AW  core result memory read address (combinational from read_addr)
res_data  in  MM_SIZE  core result data, synchronous, valid one cycle after res_addr
start  out  1  one-cycle core start pulse
core_busy  in  1  core computing
core_done  in  1  one-cycle completion pulse

Behaviour:
- Address map:
  - 0x00000-0x03FFF: RESULT, read-only; res_addr = addr[13:0].
  - 0x04000: CTRL, write bit0 = start request.
  - 0x04001: STATUS, read-only: bit0 busy, bit1 done (sticky), bit2 overflow (sticky), bits[5:3] fifo count. Other bits 0.
  - 0x04002-0x07FFF: DATA window; core address = addr - 2.
  - All other addresses: writes ignored, reads return 0.
- Reset values: read_data 0, mem_we 0, mem_addr 0, mem_wdata 0, start 0, busy 0. FIFO empty, done 0, overflow 0, FSM IDLE.
- Posted writes:
  - A DATA write pushes {addr-2, data}.
  - Pop when FIFO non-empty and mem_ready. mem_we/mem_addr/mem_wdata are the FIFO head, combinational.
  - Push and pop in the same cycle are both performed, including when full; count is unchanged.
  - Push when full without a pop: packet dropped, overflow set.
  - FIFO order is strictly preserved. Pointers wrap modulo FIFO_DEPTH.
- Read path:
  - read_data is registered at the next posedge.
  - RESULT: the region select is registered; read_data mirrors res_data after the edge.
  - STATUS/unmapped: the value is registered.
  - Reads have no side effects. An X read_addr yields don't-care data and no state change.
- Start FSM (states IDLE, PEND, RUN):
  - IDLE: CTRL write with bit0=1 -> PEND. The same write clears done.
  - PEND: when FIFO empty and core_busy=0, assert start for exactly one cycle -> RUN.
  - RUN: core_done -> IDLE and set done.
  - CTRL writes in PEND/RUN are ignored.
  - core_done seen in IDLE or PEND sets done and causes no transition.
- busy = FIFO non-empty | state != IDLE | core_busy. It is registered, so it reflects the state after each edge.
- Simultaneous CTRL and DATA writes cannot occur (single write port). A start request placed behind queued DATA writes always waits for the drain.
- Reset mid-operation: FIFO contents discarded, FSM to IDLE, sticky bits cleared. A pending start is never emitted.

Test Plan:
- Reset, then read 0x04001 -> read_data=0x0000 one cycle later; busy=0.
- mem_ready=1, write 0x04002=512 and 0x04005=2000 -> mem_we pulses with mem_addr 0 then 3 and mem_wdata 512 then 2000, in order; count returns to 0.
- mem_ready=0, write five DATA packets -> first four queued; STATUS reads overflow=1, count=4. mem_ready=1 -> exactly four drain, in order.
- Queue 2 packets with mem_ready=0, then write 0x04000=1 -> no start. Raise mem_ready -> start pulses one cycle after the FIFO empties. core_done -> STATUS done=1, busy=0.
- Result stub returns addr+0x100; read 0x0, 0x1, 0x2 on consecutive cycles -> read_data 0x100, 0x101, 0x102 on the following three cycles.
- Assert reset while in PEND with 3 queued entries -> mem_we=0, start never pulses, STATUS=0 after reset.
